// File: rtl/alu_arb_pkg.sv
// Shared types and default widths for the ALU arbiter.
// Function codes live with the ALU itself; this package never decodes them.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_arb_state_t;

  localparam int NUM_REQ_DEF     = 2;
  localparam int DATA_W_DEF      = 32;
  localparam int FUNC_W_DEF      = 6;
  localparam int FLAG_W_DEF      = 4;
  localparam int ALU_LATENCY_DEF = 1;

endpackage

// File: rtl/rr_grant.sv
// Grant picker: first requester at or after i_ptr, wrapping. Building with
// ALU_ARB_FIXED_PRIO_EN selects fixed priority instead (lowest index wins, i_ptr ignored).
module rr_grant #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  // Scan from the top so the lowest valid index is written last and wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        o_grant = NUM_REQ'(1) << k;
        o_idx   = IDX_W'(k);
      end
    end
  end
`else
  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  // NOTE: every output gets a default before the loop, otherwise a path that
  // assigns nothing would infer a latch.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        o_grant = NUM_REQ'(1) << w_idx;
        o_idx   = w_idx;
      end
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU among NUM_REQ valid/ready requesters, one op in flight.
// Define ALU_ARB_FIXED_PRIO_EN for fixed-priority grant instead of round-robin.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FUNC_W      = FUNC_W_DEF,
  parameter int FLAG_W      = FLAG_W_DEF,
  parameter int ALU_LATENCY = ALU_LATENCY_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*FUNC_W-1:0] req_func,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_result,
  output logic [FLAG_W-1:0]         rsp_flags,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [FUNC_W-1:0]         alu_func,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic [FLAG_W-1:0]         alu_flags,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ALU_LATENCY + 1);

  alu_arb_state_t     r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_alu_a;
  logic [DATA_W-1:0]  r_alu_b;
  logic [FUNC_W-1:0]  r_alu_func;
  logic [DATA_W-1:0]  r_rsp_result;
  logic [FLAG_W-1:0]  r_rsp_flags;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic [IDX_W-1:0]   w_ptr;
  logic [DATA_W-1:0]  w_sel_a;
  logic [DATA_W-1:0]  w_sel_b;
  logic [FUNC_W-1:0]  w_sel_func;
  logic               w_idle;
  logic               w_rsp_done;

  assign w_idle     = (r_state == IDLE);
  assign w_rsp_done = (r_state == RESP) && |(r_rsp_valid & rsp_ready);

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_grant (
    .i_req   (req_valid),
    .i_ptr   (w_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gnt_idx)
  );

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] r_ptr;

  // Pointer moves past the requester just served, so it goes last next round.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_rsp_done) begin
      r_ptr <= (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + IDX_W'(1);
    end
  end
  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  always_comb begin
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_sel_func = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == IDX_W'(i)) begin
        w_sel_a    = req_a[i*DATA_W +: DATA_W];
        w_sel_b    = req_b[i*DATA_W +: DATA_W];
        w_sel_func = req_func[i*FUNC_W +: FUNC_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_gnt_idx    <= '0;
      r_rsp_valid  <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_func   <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_alu_a    <= w_sel_a;
            r_alu_b    <= w_sel_b;
            r_alu_func <= w_sel_func;
            r_gnt_idx  <= w_gnt_idx;
            r_cnt      <= CNT_W'(ALU_LATENCY);
            r_state    <= EXEC;
          end
        end
        EXEC: begin
          if (r_cnt == '0) begin
            r_rsp_result <= alu_result;
            r_rsp_flags  <= alu_flags;
            r_rsp_valid  <= NUM_REQ'(1) << r_gnt_idx;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (w_rsp_done) begin
            r_rsp_valid <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Reset masks the combinational grant so req_ready reads 0 while rst is high.
  assign req_ready  = (w_idle && !rst) ? w_grant : '0;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_func   = r_alu_func;
  assign busy       = !w_idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random traffic,
// with a transaction-level model of grant order, response timing and ALU results.
module tb_alu_arbiter;

  localparam int N   = 2;
  localparam int DW  = 32;
  localparam int FW  = 6;
  localparam int FLW = 4;
  localparam int LAT = 1;

  localparam logic [FW-1:0] F_ADD = 6'd0;
  localparam logic [FW-1:0] F_SUB = 6'd1;
  localparam logic [FW-1:0] F_AND = 6'd2;
  localparam logic [FW-1:0] F_XOR = 6'd3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*DW-1:0] req_a, req_b;
  logic [N*FW-1:0] req_func;
  logic [DW-1:0]   rsp_result, alu_a, alu_b, alu_result;
  logic [FLW-1:0]  rsp_flags, alu_flags;
  logic [FW-1:0]   alu_func;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  // requester side
  bit             pend [N];
  bit             acc  [N];
  logic [DW-1:0]  pa   [N];
  logic [DW-1:0]  pb   [N];
  logic [FW-1:0]  pf   [N];

  // transaction model
  int             cyc_n;
  bit             m_busy;
  int             m_g;
  int             m_rise;
  int             m_ptr;
  logic [DW-1:0]  m_a, m_b, m_res;
  logic [FW-1:0]  m_f;
  logic [FLW-1:0] m_flg, m_cap_flg;

  // observations
  int             n_rsp;
  int             order_q [$];
  logic [DW-1:0]  res_q [$];
  logic [DW-1:0]  last_res;
  logic [FLW-1:0] last_flg, last_cap;
  int             last_g;
  int             obs_acc, obs_rise;
  bit             prev_rv;

  alu_arbiter #(
    .NUM_REQ     (N),
    .DATA_W      (DW),
    .FUNC_W      (FW),
    .FLAG_W      (FLW),
    .ALU_LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_func   (req_func),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_func   (alu_func),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [FW-1:0] f);
    case (f)
      F_ADD:   return a + b;
      F_SUB:   return a - b;
      F_AND:   return a & b;
      F_XOR:   return a ^ b;
      default: return a;
    endcase
  endfunction

  function automatic logic [FLW-1:0] alu_flg(input logic [DW-1:0] r, input logic [FW-1:0] f);
    return {r == '0, r[DW-1], ^r, f[0]};
  endfunction

  // ALU stand-in: LAT register stages from alu_a/b/func to alu_result/flags.
  logic [DW-1:0]  pipe_r [LAT];
  logic [FLW-1:0] pipe_f [LAT];
  always @(posedge clk) begin
    pipe_r[0] <= alu_op(alu_a, alu_b, alu_func);
    pipe_f[0] <= alu_flg(alu_op(alu_a, alu_b, alu_func), alu_func);
    for (int i = 1; i < LAT; i++) begin
      pipe_r[i] <= pipe_r[i-1];
      pipe_f[i] <= pipe_f[i-1];
    end
  end
  assign alu_result = pipe_r[LAT-1];
  assign alu_flags  = pipe_f[LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit any_pend();
    bit r = 1'b0;
    for (int i = 0; i < N; i++) r |= pend[i];
    return r;
  endfunction

  function automatic int rr_pick();
    for (int k = 0; k < N; k++) begin
      if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      req_valid[i]             = pend[i];
      req_a[i*DW +: DW]        = pa[i];
      req_b[i*DW +: DW]        = pb[i];
      req_func[i*FW +: FW]     = pf[i];
    end
  endtask

  task automatic post(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [FW-1:0] f);
    pend[i] = 1'b1;
    pa[i]   = a;
    pb[i]   = b;
    pf[i]   = f;
    drive_req();
  endtask

  // Compare DUT outputs with the model at the negedge, then advance the model.
  task automatic monitor();
    int           g;
    logic [N-1:0] exp_ready, exp_rv;
    g         = m_busy ? -1 : rr_pick();
    exp_ready = (g >= 0) ? (N'(1) << g) : '0;
    exp_rv    = (m_busy && cyc_n >= m_rise) ? (N'(1) << m_g) : '0;
    check("req_ready", req_ready, exp_ready);
    check("busy", busy, m_busy);
    check("rsp_valid", rsp_valid, exp_rv);
    if (req_ready != '0) obs_acc = cyc_n;
    if (rsp_valid != '0 && !prev_rv) obs_rise = cyc_n;
    prev_rv = (rsp_valid != '0);
    if (m_busy && cyc_n < m_rise) begin
      check("alu_a_held", alu_a, m_a);
      check("alu_b_held", alu_b, m_b);
      check("alu_func_held", alu_func, m_f);
    end
    if (m_busy && cyc_n == m_rise - 1) m_cap_flg = alu_flags;
    if (exp_rv != '0) begin
      check("rsp_result", rsp_result, m_res);
      check("rsp_flags", rsp_flags, m_flg);
      check("rsp_flags_vs_capture", rsp_flags, m_cap_flg);
      if (rsp_ready[m_g]) begin
        last_res = rsp_result;
        last_flg = rsp_flags;
        last_cap = m_cap_flg;
        last_g   = m_g;
        res_q.push_back(rsp_result);
        n_rsp++;
        m_busy = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        m_ptr = 0;
`else
        m_ptr = (m_g + 1) % N;
`endif
      end
    end else if (g >= 0) begin
      acc[g] = 1'b1;
      m_busy = 1'b1;
      m_g    = g;
      m_rise = cyc_n + LAT + 2;
      m_a    = pa[g];
      m_b    = pb[g];
      m_f    = pf[g];
      m_res  = alu_op(pa[g], pb[g], pf[g]);
      m_flg  = alu_flg(m_res, pf[g]);
      order_q.push_back(g);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc_n++;
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        pend[i] = 1'b0;
        acc[i]  = 1'b0;
      end
    end
    drive_req();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    cyc_n++;
    #1;
    rst    = 1'b0;
    m_busy = 1'b0;
    m_ptr  = 0;
    for (int i = 0; i < N; i++) acc[i] = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = '1;
    for (int k = 0; k < 80 && (any_pend() || m_busy); k++) cyc();
    check("drain_idle", {any_pend(), m_busy}, 0);
  endtask

  initial begin
    int start;
    int exp_ord [4];
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_ord = '{0, 0, 0, 0};
`else
    exp_ord = '{0, 1, 0, 1};
`endif
    rst = 1'b1;
    rsp_ready = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; acc[i] = 1'b0; pa[i] = '0; pb[i] = '0; pf[i] = '0;
    end
    drive_req();
    cyc_n = 0; m_busy = 1'b0; m_ptr = 0; n_rsp = 0; prev_rv = 1'b0;
    obs_acc = 0; obs_rise = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_func", alu_func, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_flags", rsp_flags, 0);
    @(posedge clk);
    cyc_n++;
    #1;

    // Single request from requester 0
    rsp_ready = '1;
    start = n_rsp;
    post(0, 100, 75, F_ADD);
    for (int k = 0; k < 20 && n_rsp == start; k++) cyc();
    check("t1_count", n_rsp, start + 1);
    check("t1_result", last_res, 175);
    check("t1_grant", last_g, 0);
    check("t1_latency", obs_rise - obs_acc, 3);

    // Simultaneous requests right after reset
    do_reset();
    order_q.delete();
    res_q.delete();
    start = n_rsp;
    post(0, 7, 7, F_SUB);
    post(1, 1024, 2048, F_ADD);
    for (int k = 0; k < 40 && n_rsp < start + 2; k++) cyc();
    check("t2_count", n_rsp, start + 2);
    check("t2_first_grant", order_q[0], 0);
    check("t2_first_result", res_q[0], 0);
    check("t2_second_grant", order_q[1], 1);
    check("t2_second_result", res_q[1], 3072);

    // Both requesters continuously valid
    do_reset();
    order_q.delete();
    start = n_rsp;
    for (int k = 0; k < 100 && n_rsp < start + 4; k++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i]) post(i, $urandom(), $urandom(), FW'($urandom_range(0, 3)));
      cyc();
    end
    check("t3_count", n_rsp, start + 4);
    for (int i = 0; i < 4; i++) check("t3_order", order_q[i], exp_ord[i]);
    drain();

    // Response back-pressure; rsp_ready of the other requester must be ignored
    do_reset();
    rsp_ready = 2'b10;
    post(0, 99, 1, F_SUB);
    for (int k = 0; k < 20 && rsp_valid == '0; k++) cyc();
    check("t4_rsp_up", rsp_valid, 2'b01);
    post(1, 5, 6, F_ADD);
    repeat (5) begin
      cyc();
      #1;
      check("t4_hold_valid", rsp_valid, 2'b01);
      check("t4_hold_result", rsp_result, 98);
      check("t4_hold_busy", busy, 1);
      check("t4_hold_ready", req_ready, 2'b00);
    end
    rsp_ready = 2'b01;
    start = n_rsp;
    cyc();
    #1;
    check("t4_released_busy", busy, 0);
    check("t4_released_count", n_rsp, start + 1);
    check("t4_next_grant", req_ready, 2'b10);
    drain();

    // Reset while the op is executing
    start = n_rsp;
    post(0, 11, 22, F_ADD);
    cyc();
    #1;
    check("t5_exec_busy", busy, 1);
    do_reset();
    #1;
    check("t5_busy", busy, 0);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_alu_a", alu_a, 0);
    order_q.delete();
    post(0, 1, 2, F_ADD);
    post(1, 3, 4, F_ADD);
    for (int k = 0; k < 20 && order_q.size() == 0; k++) cyc();
    check("t5_grant_after_reset", order_q[0], 0);
    drain();
    check("t5_discarded", n_rsp, start + 2);

    // Signed operands are passed through untouched
    start = n_rsp;
    post(1, 9999, 32'(-999), F_SUB);
    for (int k = 0; k < 20 && n_rsp == start; k++) cyc();
    check("t6_count", n_rsp, start + 1);
    check("t6_grant", last_g, 1);
    check("t6_result", last_res, 10998);
    check("t6_flags", last_flg, last_cap);

    // Random traffic with random response back-pressure
    start = n_rsp;
    for (int k = 0; k < 400; k++) begin
      rsp_ready = N'($urandom());
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0)
          post(i, $urandom(), $urandom(), FW'($urandom_range(0, 4)));
      cyc();
    end
    drain();
    check("rand_progress", n_rsp > start + 10, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single `alu` instance between `NUM_REQ` requesters, such as the decode and address-generation paths, using valid/ready request and response channels. It grants one requester at a time, round-robin by default. The block registers that requester's operands and function onto the ALU inputs, waits out the ALU latency, and captures `result`/`flags` into a per-requester response channel held until accepted. There is one operation in flight at most, with no pipelining across requesters.

## Interface
- `NUM_REQ`, 2: number of requesters, legal range 2..4.
- `DATA_W`, 32: operand and result width.
- `FUNC_W`, 6: ALU function code width.
- `FLAG_W`, 4: ALU flags width.
- `ALU_LATENCY`, 1: clock edges from stable ALU inputs to valid `result`/`flags`, minimum 1.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NUM_REQ: request valid, one bit per requester.
- `req_ready` output NUM_REQ: request accepted this cycle, one-hot or zero.
- `req_a`, `req_b` input NUM_REQ*DATA_W: operands; requester i uses slice [i*DATA_W +: DATA_W].
- `req_func` input NUM_REQ*FUNC_W: function code, passed to the ALU unmodified.
- `rsp_valid` output NUM_REQ: response valid, one-hot or zero.
- `rsp_ready` input NUM_REQ: response accepted.
- `rsp_result` output DATA_W: captured result, shared by all requesters and qualified by `rsp_valid`.
- `rsp_flags` output FLAG_W: captured flags.
- `alu_a`, `alu_b` output DATA_W: registered operands driven to the ALU.
- `alu_func` output FUNC_W: registered function code driven to the ALU.
- `alu_result` input DATA_W: ALU result.
- `alu_flags` input FLAG_W: ALU flags.
- `busy` output 1: high in any state other than IDLE.

## Operation
- States:
  - IDLE: no operation held.
  - EXEC: operation issued to the ALU, counting down.
  - RESP: response held for the granted requester.
- IDLE:
  - If any `req_valid` is high, pick grant g and assert `req_ready[g]` combinationally.
  - At that edge, register `req_a/b/func[g]` into `alu_a/b/func`, store g, load counter = ALU_LATENCY, and go to EXEC.
- EXEC:
  - `alu_*` held stable.
  - Counter decrements each edge.
  - On the edge where the counter is 0, capture `alu_result`/`alu_flags` into `rsp_result`/`rsp_flags` and go to RESP.
- RESP:
  - `rsp_valid[g]` = 1 and all `req_ready` = 0.
  - On `rsp_valid[g] && rsp_ready[g]`, go to IDLE and set the round-robin pointer to (g+1) mod NUM_REQ.
- Grant rule: the first valid requester at or after the pointer, wrapping.
- `rsp_ready[j]` for j≠g is ignored.
- Requester obligations:
  - `req_valid` must hold until `req_ready`.
  - Request data may change freely while not ready.
- Operands are not modified. Width and sign semantics belong to the ALU, e.g. 9999 − (−999) yields 10998 two's-complement.
- A request that becomes valid during EXEC/RESP waits; it is never dropped.

## Timing
- Reset values:
  - state IDLE, pointer 0, counter 0.
  - `req_ready`, `rsp_valid`, `busy` = 0.
  - `alu_a`, `alu_b`, `alu_func`, `rsp_result`, `rsp_flags` = 0.
- Accept edge E0: `alu_*` valid from E0.
- Result capture: at edge E0+ALU_LATENCY+1.
- `rsp_valid` rises in the cycle after E0+ALU_LATENCY+1. With ALU_LATENCY=1, that is the cycle after E0+2.
- With `rsp_ready` held high:
  - Return to IDLE at E0+ALU_LATENCY+2.
  - Next accept at E0+ALU_LATENCY+3.
  - Peak throughput is one op per ALU_LATENCY+3 cycles.
- Reset during EXEC or RESP: at the next edge everything returns to reset values. The in-flight op is discarded and no response is issued.
- Reset has priority over every same-edge event.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest valid index wins. The pointer is not implemented.
- Undefined (default): round-robin as described above.
- Both modes have identical ports and timing.

## Structure
- Package `alu_arb_pkg` holds:
  - `alu_arb_state_t` enum {IDLE, EXEC, RESP}.
  - Localparam defaults for `DATA_W`/`FUNC_W`/`FLAG_W`.
- Function codes remain in `alu.svh`.
- Sub-module `rr_grant`:
  - Inputs: `NUM_REQ` request vector and pointer.
  - Outputs: one-hot grant and index.
  - Fixed-priority mode is a build option inside it.

## Test plan
- req0 only, 100, 75, `func_add` → `req_ready` = 01 at E0. After E0+2 (`rsp_valid` rises), `rsp_valid` = 01 and `rsp_result` = 175. `req_ready[1]` is never asserted.
- req0 (7, 7, `func_sub`) and req1 (1024, 2048, `func_add`) valid on the same cycle after reset → req0 served first with result 0, then req1 with 3072. `rsp_valid` is never 11.
- Both requesters continuously valid, 4 ops → grant order 0,1,0,1. With `ALU_ARB_FIXED_PRIO_EN` the order is 0,0,0,0.
- req0 (99, 1, `func_sub`) with `rsp_ready` = 0 for 5 cycles → `rsp_valid[0]` stays 1, `rsp_result` = 98 stable, `busy` = 1, `req_ready` = 00. Released on the cycle ready rises.
- `rst` pulsed during EXEC → next cycle `busy` = 0, `rsp_valid` = 00, `alu_a` = 0. The next simultaneous request grants req0.
- req1 (9999, −999, `func_sub`) → `rsp_result` = 10998, `rsp_flags` equals `alu_flags` sampled at the capture edge.
